// File: rtl/countdown_timer_ms.sv
// rtl/countdown_timer_ms.sv - minutes:seconds countdown timer with load/start/pause/clear control
//
// Counts a loaded mm:ss value down to 00:00, one step every TICK_DIV clocks,
// and raises a one-cycle done pulse on the edge the count reaches zero.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset
//   load       load load_mins/load_secs (ignored while running)
//   load_mins  start minutes, clamped to FN
//   load_secs  start seconds, clamped to FN
//   start      IDLE/PAUSE/DONE -> RUN (or straight to DONE when time is 00:00)
//   pause      RUN -> PAUSE, time and prescaler frozen
//   clear      abort: time <- 00:00, state <- IDLE
//   mins       current minutes (registered)
//   secs       current seconds (registered)
//   running    high while counting
//   expired    high while in DONE
//   done       one-cycle pulse when the count reaches 00:00
module countdown_timer_ms #(
  parameter int FN       = 59,
  parameter int TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [5:0] load_mins,
  input  logic [5:0] load_secs,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [5:0] mins,
  output logic [5:0] secs,
  output logic       running,
  output logic       expired,
  output logic       done
);

  // A one-bit prescaler is kept even for TICK_DIV=1, where it simply stays 0.
  localparam int              PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [5:0]      FMAX  = 6'(FN);
  localparam logic [PW-1:0]   PLAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]   PONE  = PW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [5:0]    mins_n, secs_n;
  logic [PW-1:0] pre, pre_n;
  logic          done_n;

  logic [5:0]    lmins_c, lsecs_c;
  logic [5:0]    dec_mins, dec_secs;
  logic          time_zero;
  logic          dec_zero;
  logic          tick;

  // Each loaded field is clamped on its own.
  assign lmins_c = (load_mins > FMAX) ? FMAX : load_mins;
  assign lsecs_c = (load_secs > FMAX) ? FMAX : load_secs;

  assign time_zero = (mins == 6'd0) && (secs == 6'd0);
  assign tick      = (pre == PLAST);

  // One-step decrement with seconds-to-minutes borrow.
  always_comb begin
    dec_mins = mins;
    dec_secs = secs;
    if (secs != 6'd0) begin
      dec_secs = secs - 6'd1;
    end else if (mins != 6'd0) begin
      dec_secs = FMAX;
      dec_mins = mins - 6'd1;
    end
  end

  assign dec_zero = (dec_mins == 6'd0) && (dec_secs == 6'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      mins    <= 6'd0;
      secs    <= 6'd0;
      pre     <= '0;
      done    <= 1'b0;
      running <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_n;
      mins    <= mins_n;
      secs    <= secs_n;
      pre     <= pre_n;
      done    <= done_n;
      running <= (state_n == S_RUN);
      expired <= (state_n == S_DONE);
    end
  end

  always_comb begin
    state_n = state;
    mins_n  = mins;
    secs_n  = secs;
    pre_n   = pre;
    done_n  = 1'b0;

    if (clear) begin
      state_n = S_IDLE;
      mins_n  = 6'd0;
      secs_n  = 6'd0;
      pre_n   = '0;
    end else begin
      case (state)
        S_RUN: begin
          // load and start have no effect while counting; pause freezes the
          // prescaler at its current value so a resume picks up mid-second.
          if (pause) begin
            state_n = S_PAUSE;
          end else if (tick) begin
            pre_n  = '0;
            mins_n = dec_mins;
            secs_n = dec_secs;
            if (dec_zero) begin
              state_n = S_DONE;
              done_n  = 1'b1;
            end
          end else begin
            pre_n = pre + PONE;
          end
        end

        default: begin
          if (load) begin
            mins_n = lmins_c;
            secs_n = lsecs_c;
            if (state == S_DONE) begin
              state_n = S_IDLE;
            end
          end else if (start) begin
            if (time_zero) begin
              // Nothing to count: expire immediately. A start while already
              // expired leaves DONE as it is and does not pulse again.
              state_n = S_DONE;
              done_n  = (state != S_DONE);
            end else begin
              state_n = S_RUN;
              if (state != S_PAUSE) begin
                pre_n = '0;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer_ms.sv
// tb/tb_countdown_timer_ms.sv - directed scoreboard bench for countdown_timer_ms
module tb_countdown_timer_ms;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [5:0] load_mins;
  logic [5:0] load_secs;
  logic       start;
  logic       pause;
  logic       clear;
  logic [5:0] mins;
  logic [5:0] secs;
  logic       running;
  logic       expired;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [5:0] m;
    logic [5:0] s;
    logic       r;
    logic       e;
    logic       d;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  countdown_timer_ms #(.FN(59), .TICK_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_mins (load_mins),
    .load_secs (load_secs),
    .start     (start),
    .pause     (pause),
    .clear     (clear),
    .mins      (mins),
    .secs      (secs),
    .running   (running),
    .expired   (expired),
    .done      (done)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic [5:0] m, input logic [5:0] s,
                      input logic r, input logic e, input logic d);
    exp_t x;
    x.tag = tag;
    x.m   = m;
    x.s   = s;
    x.r   = r;
    x.e   = e;
    x.d   = d;
    sb.push_back(x);
  endtask

  task automatic pop_check();
    exp_t x;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      x = sb.pop_front();
      chk({x.tag, ".mins"},    {2'b00, mins},          {2'b00, x.m});
      chk({x.tag, ".secs"},    {2'b00, secs},          {2'b00, x.s});
      chk({x.tag, ".running"}, {7'd0, running},        {7'd0, x.r});
      chk({x.tag, ".expired"}, {7'd0, expired},        {7'd0, x.e});
      chk({x.tag, ".done"},    {7'd0, done},           {7'd0, x.d});
    end
  endtask

  // Expectation goes into the scoreboard with the stimulus, then n edges
  // later the DUT outputs are compared against it.
  task automatic step(input string tag, input int n, input logic [5:0] m, input logic [5:0] s,
                      input logic r, input logic e, input logic d);
    push(tag, m, s, r, e, d);
    cyc(n);
    pop_check();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
    load_mins = 6'd0; load_secs = 6'd0;
    @(negedge clk);
    step("reset", 2, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // 00:03 countdown: decrements at E+4, E+8, E+12; done only at E+12.
    load = 1'b1; load_mins = 6'd0; load_secs = 6'd3;
    step("t1_load", 1, 6'd0, 6'd3, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    start = 1'b1;
    step("t1_start", 1, 6'd0, 6'd3, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    step("t1_e3",  3, 6'd0, 6'd3, 1'b1, 1'b0, 1'b0);
    step("t1_e4",  1, 6'd0, 6'd2, 1'b1, 1'b0, 1'b0);
    step("t1_e8",  4, 6'd0, 6'd1, 1'b1, 1'b0, 1'b0);
    step("t1_e11", 3, 6'd0, 6'd1, 1'b1, 1'b0, 1'b0);
    step("t1_e12", 1, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1);
    step("t1_e13", 1, 6'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    step("t1_hold", 5, 6'd0, 6'd0, 1'b0, 1'b1, 1'b0);

    // Clamping, load from DONE returns to IDLE, start at 00:00 expires at once.
    load = 1'b1; load_mins = 6'd63; load_secs = 6'd62;
    step("t3_clamp", 1, 6'd59, 6'd59, 1'b0, 1'b0, 1'b0);
    load_mins = 6'd5; load_secs = 6'd60;
    step("t3_clamp_secs", 1, 6'd5, 6'd59, 1'b0, 1'b0, 1'b0);
    load_mins = 6'd0; load_secs = 6'd0;
    step("t3_zero", 1, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    start = 1'b1;
    step("t3_start_zero", 1, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1);
    start = 1'b0;
    step("t3_after", 1, 6'd0, 6'd0, 1'b0, 1'b1, 1'b0);

    // 01:00: borrow after 4 cycles, done after 240.
    load = 1'b1; load_mins = 6'd1; load_secs = 6'd0;
    step("t2_load", 1, 6'd1, 6'd0, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    start = 1'b1;
    step("t2_start", 1, 6'd1, 6'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    step("t2_borrow", 4, 6'd0, 6'd59, 1'b1, 1'b0, 1'b0);
    n = 4;
    while (done !== 1'b1 && n < 400) begin
      cyc(1);
      n++;
    end
    chk("t2_latency_lo", n[7:0], 8'd240);
    chk("t2_latency_hi", {7'd0, n > 255}, 8'd0);
    step("t2_done", 0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1);

    // Pause with prescaler mid-count, hold, resume two cycles from a decrement.
    load = 1'b1; load_mins = 6'd0; load_secs = 6'd5;
    step("t4_load", 1, 6'd0, 6'd5, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    start = 1'b1;
    step("t4_start", 1, 6'd0, 6'd5, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    step("t4_run6", 6, 6'd0, 6'd4, 1'b1, 1'b0, 1'b0);
    pause = 1'b1;
    step("t4_pause", 1, 6'd0, 6'd4, 1'b0, 1'b0, 1'b0);
    pause = 1'b0;
    step("t4_hold", 10, 6'd0, 6'd4, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    step("t4_resume", 1, 6'd0, 6'd4, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    step("t4_r1", 1, 6'd0, 6'd4, 1'b1, 1'b0, 1'b0);
    step("t4_r2", 1, 6'd0, 6'd3, 1'b1, 1'b0, 1'b0);

    // Clear from RUN, clear beating load, load/start ignored while running.
    clear = 1'b1;
    step("t5_clear_pre", 1, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    load = 1'b1; load_mins = 6'd2; load_secs = 6'd0;
    step("t5_clear_beats_load", 1, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    clear = 1'b0;
    load_mins = 6'd0; load_secs = 6'd11;
    step("t5_load", 1, 6'd0, 6'd11, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    start = 1'b1;
    step("t5_start", 1, 6'd0, 6'd11, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    step("t5_at10", 4, 6'd0, 6'd10, 1'b1, 1'b0, 1'b0);
    load = 1'b1; load_mins = 6'd2; load_secs = 6'd0; start = 1'b1;
    step("t5_load_ignored", 1, 6'd0, 6'd10, 1'b1, 1'b0, 1'b0);
    load = 1'b0; start = 1'b0;
    step("t5_continue", 3, 6'd0, 6'd9, 1'b1, 1'b0, 1'b0);
    clear = 1'b1;
    step("t5_clear", 1, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    clear = 1'b0;
    step("t5_idle", 3, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);

    // load + start together: only the load lands; pause in IDLE does nothing.
    load = 1'b1; start = 1'b1; load_mins = 6'd0; load_secs = 6'd4;
    step("ls_load_only", 1, 6'd0, 6'd4, 1'b0, 1'b0, 1'b0);
    load = 1'b0; start = 1'b0;
    step("ls_stays_idle", 3, 6'd0, 6'd4, 1'b0, 1'b0, 1'b0);
    pause = 1'b1;
    step("pause_idle", 1, 6'd0, 6'd4, 1'b0, 1'b0, 1'b0);
    pause = 1'b0;

    // Reset mid-RUN at 00:07, then start at 00:00 goes straight to DONE.
    load = 1'b1; load_mins = 6'd0; load_secs = 6'd8;
    step("t6_load", 1, 6'd0, 6'd8, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    start = 1'b1;
    step("t6_start", 1, 6'd0, 6'd8, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    step("t6_at7", 4, 6'd0, 6'd7, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    step("t6_rst", 1, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    start = 1'b1;
    step("t6_start_zero", 1, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1);
    start = 1'b0;
    step("t6_done_clr", 1, 6'd0, 6'd0, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
